// File: rtl/frame_energy_vad.sv
// Purpose: per-frame |sample-128| energy with a hysteresis voice-activity FSM.
// Latency: energy and VAD outputs update 1 cycle after the frame-end sample strobe.
// Backpressure: one-deep output register; a frame finishing while the output is still unconsumed is dropped and overrun pulses.
module frame_energy_vad #(
  parameter int FRAME_LEN    = 64,
  parameter int ENERGY_W     = 16,
  parameter int ON_THRESH    = 1024,
  parameter int OFF_THRESH   = 512,
  parameter int ONSET_FRAMES = 2,
  parameter int HANG_FRAMES  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          sample,
  input  logic                sample_valid,
  output logic [ENERGY_W-1:0] energy,
  output logic                energy_valid,
  input  logic                energy_ready,
  output logic                speech_active,
  output logic                utterance_start,
  output logic                utterance_end,
  output logic                overrun
);

  localparam int CNT_W   = $clog2(FRAME_LEN);
  localparam int RUN_MAX = (ONSET_FRAMES > HANG_FRAMES) ? ONSET_FRAMES : HANG_FRAMES;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [CNT_W-1:0]    LAST_IDX   = CNT_W'(FRAME_LEN - 1);
  localparam logic [ENERGY_W-1:0] ON_T       = ENERGY_W'(ON_THRESH);
  localparam logic [ENERGY_W-1:0] OFF_T      = ENERGY_W'(OFF_THRESH);
  localparam logic [RUN_W-1:0]    ONSET_LAST = RUN_W'(ONSET_FRAMES - 1);
  localparam logic [RUN_W-1:0]    HANG_LAST  = RUN_W'(HANG_FRAMES - 1);

  typedef enum logic [1:0] {SILENCE, ONSET, SPEECH, HANGOVER} vad_state_t;

  logic [CNT_W-1:0]    count;
  logic [ENERGY_W-1:0] acc;
  logic [7:0]          dev;
  logic [ENERGY_W:0]   sum;
  logic [ENERGY_W-1:0] frame_e;
  logic                frame_end;
  vad_state_t          state;
  logic [RUN_W-1:0]    run;

  // Deviation from the offset-binary midpoint and the saturating running sum.
  always_comb begin
    dev       = (sample >= 8'd128) ? (sample - 8'd128) : (8'd128 - sample);
    sum       = (ENERGY_W+1)'(acc) + (ENERGY_W+1)'(dev);
    frame_e   = sum[ENERGY_W] ? {ENERGY_W{1'b1}} : sum[ENERGY_W-1:0];
    frame_end = sample_valid && (count == LAST_IDX);
  end

  // Frame accumulator: clears on the frame-end strobe so the next sample starts a fresh frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      acc   <= '0;
    end else if (frame_end) begin
      count <= '0;
      acc   <= '0;
    end else if (sample_valid) begin
      count <= count + CNT_W'(1);
      acc   <= frame_e;
    end
  end

  // One-deep output register: load when empty or being drained, otherwise drop and flag overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      energy       <= '0;
      energy_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_end) begin
        if (!energy_valid || energy_ready) begin
          energy       <= frame_e;
          energy_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (energy_valid && energy_ready) begin
        energy_valid <= 1'b0;
      end
    end
  end

  // Hysteresis VAD: advances once per completed frame, regardless of output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= SILENCE;
      run             <= '0;
      speech_active   <= 1'b0;
      utterance_start <= 1'b0;
      utterance_end   <= 1'b0;
    end else begin
      utterance_start <= 1'b0;
      utterance_end   <= 1'b0;
      if (frame_end) begin
        case (state)
          SILENCE: begin
            if (frame_e >= ON_T) begin
              if (ONSET_FRAMES == 1) begin
                state           <= SPEECH;
                speech_active   <= 1'b1;
                utterance_start <= 1'b1;
              end else begin
                state <= ONSET;
                run   <= RUN_W'(1);
              end
            end
          end
          ONSET: begin
            if (frame_e >= ON_T) begin
              if (run == ONSET_LAST) begin
                state           <= SPEECH;
                speech_active   <= 1'b1;
                utterance_start <= 1'b1;
              end else begin
                run <= run + RUN_W'(1);
              end
            end else begin
              state <= SILENCE;
            end
          end
          SPEECH: begin
            if (frame_e < OFF_T) begin
              if (HANG_FRAMES == 1) begin
                state         <= SILENCE;
                speech_active <= 1'b0;
                utterance_end <= 1'b1;
              end else begin
                state <= HANGOVER;
                run   <= RUN_W'(1);
              end
            end
          end
          HANGOVER: begin
            if (frame_e >= OFF_T) begin
              state <= SPEECH;
            end else if (run == HANG_LAST) begin
              state         <= SILENCE;
              speech_active <= 1'b0;
              utterance_end <= 1'b1;
            end else begin
              run <= run + RUN_W'(1);
            end
          end
          default: begin
            state         <= SILENCE;
            speech_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_energy_vad.sv
// Bench for frame_energy_vad: two instances (16-bit and 8-bit energy) share one stimulus stream.
// Expected values come from a frame-level model: exact sum clamped to width, run-length VAD.
// Directed spec scenarios first, then randomized traffic with random ready and occasional resets.
module tb_frame_energy_vad;

  localparam int FL    = 4;
  localparam int ON    = 200;
  localparam int OFF   = 100;
  localparam int ONSET = 2;
  localparam int HANG  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sample = 8'd128;
  logic        sample_valid = 1'b0;
  logic        energy_ready = 1'b0;

  logic [15:0] e16;
  logic        v16, act16, st16, en16, ov16;
  logic [7:0]  e8;
  logic        v8, act8, st8, en8, ov8;

  int tests = 0;
  int fails = 0;

  frame_energy_vad #(.FRAME_LEN(FL), .ENERGY_W(16), .ON_THRESH(ON), .OFF_THRESH(OFF),
                     .ONSET_FRAMES(ONSET), .HANG_FRAMES(HANG)) dut16 (
    .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
    .energy(e16), .energy_valid(v16), .energy_ready(energy_ready),
    .speech_active(act16), .utterance_start(st16), .utterance_end(en16), .overrun(ov16));

  frame_energy_vad #(.FRAME_LEN(FL), .ENERGY_W(8), .ON_THRESH(ON), .OFF_THRESH(OFF),
                     .ONSET_FRAMES(ONSET), .HANG_FRAMES(HANG)) dut8 (
    .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
    .energy(e8), .energy_valid(v8), .energy_ready(energy_ready),
    .speech_active(act8), .utterance_start(st8), .utterance_end(en8), .overrun(ov8));

  always #5 clk = ~clk;

  // Reference model state, index 0 = 16-bit instance, 1 = 8-bit instance.
  int frame_q[$];
  int max_e[2] = '{65535, 255};
  int exp_e[2];
  bit exp_v[2], exp_act[2], exp_st[2], exp_en[2], exp_ov[2];
  int loud_run[2], quiet_run[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    for (int i = 0; i < 2; i++) begin
      exp_e[i] = 0; exp_v[i] = 0; exp_act[i] = 0; exp_st[i] = 0; exp_en[i] = 0; exp_ov[i] = 0;
      loud_run[i] = 0; quiet_run[i] = 0;
    end
  endtask

  // Speech is declared after ONSET consecutive loud frames, ended after HANG consecutive quiet ones.
  task automatic vad(input int i, input int fe);
    if (!exp_act[i]) begin
      loud_run[i] = (fe >= ON) ? loud_run[i] + 1 : 0;
      if (loud_run[i] == ONSET) begin
        exp_act[i] = 1; exp_st[i] = 1; loud_run[i] = 0; quiet_run[i] = 0;
      end
    end else begin
      quiet_run[i] = (fe < OFF) ? quiet_run[i] + 1 : 0;
      if (quiet_run[i] == HANG) begin
        exp_act[i] = 0; exp_en[i] = 1; quiet_run[i] = 0; loud_run[i] = 0;
      end
    end
  endtask

  task automatic model_step();
    bit done = 0;
    int total = 0;
    if (sample_valid) begin
      frame_q.push_back(int'(sample));
      if (frame_q.size() == FL) begin
        foreach (frame_q[k]) total += (frame_q[k] >= 128) ? frame_q[k] - 128 : 128 - frame_q[k];
        frame_q.delete();
        done = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      int fe;
      exp_st[i] = 0; exp_en[i] = 0; exp_ov[i] = 0;
      if (done) begin
        fe = (total > max_e[i]) ? max_e[i] : total;
        if (!exp_v[i] || energy_ready) begin
          exp_e[i] = fe; exp_v[i] = 1;
        end else begin
          exp_ov[i] = 1;
        end
        vad(i, fe);
      end else if (exp_v[i] && energy_ready) begin
        exp_v[i] = 0;
      end
    end
  endtask

  task automatic chk_dut(input int i, input logic [15:0] e, input logic v, input logic a,
                         input logic s, input logic n, input logic o);
    chk($sformatf("d%0d_energy", i), 32'(e), 32'(exp_e[i]));
    chk($sformatf("d%0d_valid", i), 32'(v), 32'(exp_v[i]));
    chk($sformatf("d%0d_active", i), 32'(a), 32'(exp_act[i]));
    chk($sformatf("d%0d_start", i), 32'(s), 32'(exp_st[i]));
    chk($sformatf("d%0d_end", i), 32'(n), 32'(exp_en[i]));
    chk($sformatf("d%0d_overrun", i), 32'(o), 32'(exp_ov[i]));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
    chk_dut(0, e16, v16, act16, st16, en16, ov16);
    chk_dut(1, {8'd0, e8}, v8, act8, st8, en8, ov8);
  endtask

  // Four back-to-back strobes whose deviations sum to e (e <= 512).
  task automatic send_frame(input int e);
    for (int k = 0; k < FL; k++) begin
      int d;
      d = e / FL + ((k < e % FL) ? 1 : 0);
      sample = 8'(128 - d);
      sample_valid = 1'b1;
      cycle();
    end
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(v16), 32'd0);
    chk("async_rst_energy", 32'(e16), 32'd0);
    cycle();
    reset = 1'b0;
    idle(1);
  endtask

  initial begin
    bit loud = 0;
    model_reset();
    cycle();
    cycle();
    chk("reset_valid", 32'(v16), 32'd0);
    chk("reset_active", 32'(act16), 32'd0);
    reset = 1'b0;
    idle(2);

    // Reset mid-frame after 2 samples; partial frame must be discarded.
    energy_ready = 1'b1;
    send_frame(512);
    chk("pre_rst_energy", 32'(e16), 32'd512);
    sample = 8'd0; sample_valid = 1'b1;
    cycle(); cycle();
    do_reset();
    energy_ready = 1'b0;
    send_frame(0);
    chk("silence_energy", 32'(e16), 32'd0);
    chk("silence_valid", 32'(v16), 32'd1);
    chk("silence_active", 32'(act16), 32'd0);

    // Energy values and 8-bit saturation.
    energy_ready = 1'b1;
    send_frame(512);
    chk("e512", 32'(e16), 32'd512);
    chk("e8_sat", 32'(e8), 32'd255);
    sample = 8'd255; sample_valid = 1'b1;
    for (int k = 0; k < FL; k++) cycle();
    sample_valid = 1'b0;
    chk("e508", 32'(e16), 32'd508);
    idle(2);

    // Backpressure: second frame dropped, overrun pulses once.
    do_reset();
    energy_ready = 1'b0;
    send_frame(512);
    chk("ovr_first", 32'(ov16), 32'd0);
    send_frame(0);
    chk("ovr_keep", 32'(e16), 32'd512);
    chk("ovr_pulse", 32'(ov16), 32'd1);
    idle(1);
    chk("ovr_once", 32'(ov16), 32'd0);
    energy_ready = 1'b1;
    idle(2);

    // Utterance with a hangover bounce.
    do_reset();
    send_frame(512);
    send_frame(512);
    chk("utt_start", 32'(st16), 32'd1);
    send_frame(50);
    chk("utt_hang1", 32'(act16), 32'd1);
    send_frame(150);
    chk("utt_back", 32'(act16), 32'd1);
    send_frame(50);
    chk("utt_hang2", 32'(act16), 32'd1);
    send_frame(50);
    chk("utt_end", 32'(en16), 32'd1);
    chk("utt_inactive", 32'(act16), 32'd0);
    idle(2);

    // Single loud frame: onset aborted, no start.
    send_frame(512);
    send_frame(50);
    chk("abort_start", 32'(st16), 32'd0);
    chk("abort_active", 32'(act16), 32'd0);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      int s;
      if ($urandom_range(0, 40) == 0) loud = ~loud;
      s = loud ? int'($urandom_range(0, 255)) : 118 + int'($urandom_range(0, 20));
      sample       = 8'(s);
      sample_valid = ($urandom_range(0, 3) != 0);
      energy_ready = ($urandom_range(0, 2) != 0);
      reset        = ($urandom_range(0, 599) == 0);
      cycle();
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
